// File: rtl/ram_pkg.sv
// Shared RAM geometry defaults and the copy-engine state encoding.
package ram_pkg;
  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_ADDR_WIDTH = 10;
  localparam int MEM_WORDS      = 1 << RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } dma_state_e;
endpackage

// File: rtl/ram_copy_check.sv
// Combinational request validator: rejects copies that run off the end of
// memory or whose destination starts inside the source (forward-unsafe).
module ram_copy_check
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  reject
);
  localparam int EW = ADDR_WIDTH + 2;

  logic [EW-1:0] src_end;
  logic [EW-1:0] dst_end;
  logic [EW-1:0] mem_words;
  logic          out_of_range;
  logic          overlap;

  always_comb begin
    src_end      = EW'(src_addr) + EW'(len);
    dst_end      = EW'(dst_addr) + EW'(len);
    mem_words    = EW'(1) << ADDR_WIDTH;
    out_of_range = (src_end > mem_words) || (dst_end > mem_words);
    // dst <= src is safe for a forward copy; only dst strictly inside src is not
    overlap      = (src_addr < dst_addr) && (EW'(dst_addr) < src_end);
    reject       = out_of_range || overlap;
  end
endmodule

// File: rtl/ram_copy_dma.sv
// Block copy engine: reads port A, writes port B one cycle later, one word/clk.
// Latency len+2 cycles from the accepting edge; start is ignored while busy.
module ram_copy_dma
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] q_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  we_b
);
  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH:0]   words_done_q, words_done_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  we_b_q, we_b_d;
  logic                  err_q, err_d;
  logic                  reject;

  ram_copy_check #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_check (
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .reject  (reject)
  );

  always_comb begin
    state_d      = state_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    dst_d        = dst_q;
    len_d        = len_q;
    rd_cnt_d     = rd_cnt_q;
    rd_vld_d     = 1'b0;
    we_b_d       = 1'b0;
    err_d        = 1'b0;
    // the write presented this cycle lands at the coming edge
    words_done_d = words_done_q + (ADDR_WIDTH+1)'(we_b_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len;
          dst_d = dst_addr;
          if (reject) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            words_done_d = '0;
            state_d      = ST_DONE;
          end else begin
            words_done_d = '0;
            addr_a_d     = src_addr;
            rd_cnt_d     = (ADDR_WIDTH+1)'(1);
            rd_vld_d     = 1'b1;
            state_d      = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          we_b_d   = rd_vld_q;
          addr_b_d = we_b_q ? addr_b_q + ADDR_WIDTH'(1) : dst_q;
          if (rd_cnt_q == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            addr_a_d = addr_a_q + ADDR_WIDTH'(1);
            rd_cnt_d = rd_cnt_q + (ADDR_WIDTH+1)'(1);
            rd_vld_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      words_done_q <= '0;
      rd_vld_q     <= 1'b0;
      we_b_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      words_done_q <= words_done_d;
      rd_vld_q     <= rd_vld_d;
      we_b_q       <= we_b_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign words_done = words_done_q;
  assign addr_a     = addr_a_q;
  assign we_a       = 1'b0;
  assign addr_b     = addr_b_q;
  assign we_b       = we_b_q;
  // read data flows straight through in the cycle it returns
  assign data_b     = we_b_q ? q_a : '0;
endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma with a behavioural dual-port RAM.
module tb_ram_copy_dma;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_done;
  logic [9:0]  addr_a;
  logic        we_a;
  logic [15:0] q_a;
  logic [9:0]  addr_b;
  logic [15:0] data_b;
  logic        we_b;

  logic [15:0] mem  [0:1023];
  logic [15:0] snap [0:1023];
  int          n_chk;
  int          n_err;
  int          wr_total;

  ram_copy_dma #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .words_done(words_done),
    .addr_a    (addr_a),
    .we_a      (we_a),
    .q_a       (q_a),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .we_b      (we_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_a <= mem[addr_a];
    if (we_b) begin
      mem[addr_b] = data_b;
      wr_total++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_copy(input int s, input int d, input int l, input int abort_wr,
                         input int restart_at, input bit abort_with_start, input int ncyc,
                         output int n_wr, output int first_wr, output int last_wr,
                         output int done_cyc, output int err_cyc, output int busy_seen,
                         output int abort_busy, output int wr_bad);
    bit prev_abort;
    n_wr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; err_cyc = -1;
    busy_seen = 0; abort_busy = -1; wr_bad = 0; prev_abort = 1'b0;
    for (int i = 0; i < 1024; i++) snap[i] = mem[i];
    src_addr = 10'(s); dst_addr = 10'(d); len = 11'(l);
    start = 1'b1; abort = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (prev_abort) abort_busy = 32'(busy);
      if (we_b) begin
        if (addr_b !== 10'(d + n_wr) || data_b !== snap[s + n_wr]) wr_bad++;
        n_wr++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (err) err_cyc = c;
      if (busy) busy_seen = 1;
      prev_abort = (abort_wr > 0) && we_b && (n_wr == abort_wr);
      abort = prev_abort;
      if (c == restart_at) begin
        start = 1'b1; src_addr = 10'd0; dst_addr = 10'd0; len = 11'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, 32'({busy, done, err, we_a, we_b}), 32'd0);
    check_eq({tag, "_addr_a"}, 32'(addr_a), 32'd0);
    check_eq({tag, "_addr_b"}, 32'(addr_b), 32'd0);
    check_eq({tag, "_data_b"}, 32'(data_b), 32'd0);
    check_eq({tag, "_words"}, 32'(words_done), 32'd0);
  endtask

  initial begin
    int n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad, bad, wt;
    n_chk = 0; n_err = 0; wr_total = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(16'h1000 + i);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // basic copy with an ignored start mid-flight
    do_copy(0, 100, 16, 0, 5, 1'b0, 22, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("basic_nwr", n_wr, 16);
    check_eq("basic_first", first_wr, 2);
    check_eq("basic_last", last_wr, 17);
    check_eq("basic_done", done_cyc, 18);
    check_eq("basic_err", err_cyc, -1);
    check_eq("basic_busy", busy_seen, 1);
    check_eq("basic_wr", wr_bad, 0);
    check_eq("basic_words", 32'(words_done), 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[100 + i] !== 16'(16'h1000 + i)) bad++;
    check_eq("basic_mem", bad, 0);

    do_copy(5, 200, 0, 0, 0, 1'b0, 4, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("zero_nwr", n_wr, 0);
    check_eq("zero_done", done_cyc, 1);
    check_eq("zero_busy", busy_seen, 0);
    check_eq("zero_err", err_cyc, -1);
    check_eq("zero_words", 32'(words_done), 0);

    do_copy(1020, 0, 8, 0, 0, 1'b0, 6, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("bsrc_err", err_cyc, 1);
    check_eq("bsrc_nwr", n_wr, 0);
    check_eq("bsrc_busy", busy_seen, 0);
    check_eq("bsrc_done", done_cyc, -1);

    do_copy(0, 1020, 8, 0, 0, 1'b0, 6, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("bdst_err", err_cyc, 1);
    check_eq("bdst_nwr", n_wr, 0);

    // ends exactly at the top word: legal
    do_copy(1016, 300, 8, 0, 0, 1'b0, 12, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("edge_done", done_cyc, 10);
    check_eq("edge_nwr", n_wr, 8);
    check_eq("edge_err", err_cyc, -1);
    check_eq("edge_mem", 32'(mem[307]), 32'h13FF);

    do_copy(10, 12, 8, 0, 0, 1'b0, 6, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("ovl_err", err_cyc, 1);
    check_eq("ovl_nwr", n_wr, 0);

    do_copy(12, 10, 8, 0, 0, 1'b0, 12, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("ovlok_done", done_cyc, 10);
    check_eq("ovlok_err", err_cyc, -1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[10 + i] !== 16'(16'h1000 + 12 + i)) bad++;
    check_eq("ovlok_mem", bad, 0);
    check_eq("ovlok_m17", 32'(mem[17]), 32'h1013);

    do_copy(400, 600, 64, 5, 0, 1'b0, 12, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("abort_nwr", n_wr, 5);
    check_eq("abort_done", done_cyc, -1);
    check_eq("abort_busy", abort_busy, 0);
    check_eq("abort_words", 32'(words_done), 5);
    check_eq("abort_m604", 32'(mem[604]), 32'h1194);
    check_eq("abort_m605", 32'(mem[605]), 32'h125D);

    // start together with abort in IDLE: start wins
    do_copy(0, 700, 4, 0, 0, 1'b1, 8, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("again_done", done_cyc, 6);
    check_eq("again_nwr", n_wr, 4);
    check_eq("again_m703", 32'(mem[703]), 32'h1003);

    do_copy(0, 0, 1024, 0, 0, 1'b0, 1030, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("full_done", done_cyc, 1026);
    check_eq("full_nwr", n_wr, 1024);
    check_eq("full_wr", wr_bad, 0);
    check_eq("full_words", 32'(words_done), 1024);

    // asynchronous reset in the middle of a copy
    src_addr = 10'd0; dst_addr = 10'd800; len = 11'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_we_b", 32'(we_b), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    wt = wr_total;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst_nowr", wr_total, wt);
    check_eq("arst_busy", 32'(busy), 0);

    do_copy(0, 900, 3, 0, 0, 1'b0, 8, n_wr, first_wr, last_wr, done_cyc, err_cyc, busy_seen, abort_busy, wr_bad);
    check_eq("post_done", done_cyc, 5);
    check_eq("post_nwr", n_wr, 3);
    check_eq("post_m902", 32'(mem[902]), 32'h1002);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_copy_dma.md
Name: ram_copy_dma

Overview:
- Initiator that drives the dual-port RAM's two ports to copy a block of words from a source region to a destination region.
- Port A is read-only (we_a tied 0); port B is write-only (we_b).
- Pipelined at one word per clock, hiding the RAM's 1-cycle synchronous read latency.
- Sits between the CPU's control registers and the data memory.

Parameters:
- DATA_WIDTH, 16, word width; matches the RAM data ports.
- ADDR_WIDTH, 10, word-address width; matches the RAM address ports.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a copy; sampled only when busy=0
- abort  in  1  cancel an in-flight copy
- src_addr  in  ADDR_WIDTH  first source word address
- dst_addr  in  ADDR_WIDTH  first destination word address
- len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse: copy completed
- err  out  1  one-cycle pulse: request rejected
- words_done  out  ADDR_WIDTH+1  words written by the current/last copy
- addr_a  out  ADDR_WIDTH  RAM port A address (read)
- we_a  out  1  constant 0
- q_a  in  DATA_WIDTH  RAM port A read data, valid 1 cycle after addr_a
- addr_b  out  ADDR_WIDTH  RAM port B address (write)
- data_b  out  DATA_WIDTH  RAM port B write data
- we_b  out  1  RAM port B write enable

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - busy, done, err, we_b, we_a = 0.
  - addr_a, addr_b, data_b, words_done = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1 at edge E0: latch src, dst, len; run the checks below in order.
  - Error, no RAM write, next cycle err=1 for one cycle, stay IDLE:
    - (a) src_addr+len > 2^ADDR_WIDTH or dst_addr+len > 2^ADDR_WIDTH (no wrap-around copies).
    - (b) forward-unsafe overlap: src_addr < dst_addr < src_addr+len.
  - len==0: done=1 the next cycle, busy stays 0, words_done=0.
  - Otherwise: words_done cleared, go to RUN, busy=1.
- RUN:
  - Cycle k (k=0..len-1 after E0) presents addr_a=src+k.
  - A registered valid bit tracks each issued read.
  - In the cycle after each read: addr_b=dst+k, data_b=q_a, we_b=1; words_done increments at that edge.
  - After the last read is issued, go to DRAIN.
- DRAIN: performs the final write, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Timing, relative to the edge after E0:
  - First read in cycle 1.
  - Writes in cycles 2..len+1.
  - done in cycle len+2.
  - Total latency len+2 cycles; steady-state throughput 1 word/clk.
- start while busy=1 is ignored (no queue).
- abort=1 in RUN or DRAIN:
  - we_b=0 from the next edge; the pending read is discarded.
  - No done pulse; busy=0; go to IDLE.
  - words_done holds the count of writes actually performed.
  - abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins.
- addr_a and addr_b hold their last values when idle; we_b is the only qualifier.
- Overlap with dst<=src is legal; a forward copy is correct.

Decomposition:
- Shared package ram_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults (shared with the RAM block).
  - State enum for IDLE/RUN/DRAIN/DONE.
  - MEM_WORDS = 2^ADDR_WIDTH.
- One natural sub-module: ram_copy_check, combinational bounds and overlap checker producing reject; the FSM/datapath stays in ram_copy_dma.

Test Plan:
- Basic copy: RAM preloaded with 0x1000+i at 0..15; start src=0, dst=100, len=16 -> writes 100..115 = 0x1000..0x100F, one per cycle in cycles 2..17, done in cycle 18, words_done=16.
- Zero length: start len=0 -> no we_b, done pulse next cycle, busy never 1, err=0.
- Bounds reject: src=1020, dst=0, len=8 -> err pulse next cycle, we_b never asserted, busy stays 0.
- Overlap: src=10, dst=12, len=8 -> err. src=12, dst=10, len=8 -> accepted; 10..17 end with old 12..19 values.
- Abort: len=64, abort asserted in the cycle of the 5th write -> exactly 5 writes, no done, busy=0 next cycle, words_done=5; a new start then succeeds.
- Reset mid-copy: rst_n low during RUN -> all outputs 0 immediately (asynchronous), no further writes after release until a new start.
